ff_bank_arbiter: RTL and testbench

FF_BANK_ARBITER -- requirements
Module: ff_bank_arbiter

---
 rtl/ff_bank_arbiter.sv | 153 +++++++++++++++
 tb/tb_ff_bank_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_arbiter.sv
// Four-requester round-robin arbiter that owns a shared WIDTH-bit flip-flop bank.
// Optional macro FFB_LOCK_EN lets the current owner hold the grant for back-to-back operations.
module ff_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [7:0]         cmd,
  input  logic [4*WIDTH-1:0] data,
  input  logic [4*WIDTH-1:0] mask,
  input  logic [3:0]         lock,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   q,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  typedef enum logic [1:0] {
    CMD_LOAD   = 2'b00,
    CMD_SET    = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_e;

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] bank_q, bank_d;

  logic [WIDTH-1:0] data_a [4];
  logic [WIDTH-1:0] mask_a [4];
  logic [1:0]       cmd_a  [4];

  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;

  cmd_e             own_cmd;
  logic [WIDTH-1:0] own_data;
  logic [WIDTH-1:0] own_mask;
  logic [WIDTH-1:0] op_val;
  logic [WIDTH-1:0] applied;

`ifndef FFB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data_a[i] = data[WIDTH*i +: WIDTH];
      mask_a[i] = mask[WIDTH*i +: WIDTH];
      cmd_a[i]  = cmd[2*i +: 2];
    end
  end

  // Scan from last winner + 1 upward; the 2-bit index wraps naturally mod 4.
  always_comb begin
    winner = last_q + 2'd1;
    cand   = last_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // The owner's slices are read live, so cmd/data/mask are sampled at the GRANT-exit edge.
  always_comb begin
    own_cmd  = cmd_e'(cmd_a[owner_q]);
    own_data = data_a[owner_q];
    own_mask = mask_a[owner_q];
    unique case (own_cmd)
      CMD_LOAD:   op_val = own_data;
      CMD_SET:    op_val = '1;
      CMD_CLEAR:  op_val = '0;
      CMD_TOGGLE: op_val = ~bank_q;
      default:    op_val = bank_q;
    endcase
    applied = (bank_q & ~own_mask) | (op_val & own_mask);
  end

  // NOTE: every *_d gets a hold default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    bank_d  = bank_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << winner;
          owner_d = winner;
          last_d  = winner;
        end else begin
          gnt_d = '0;
        end
      end
      ST_GRANT: begin
        bank_d = applied;
`ifdef FFB_LOCK_EN
        if (lock[owner_q] && req[owner_q]) begin
          state_d = ST_GRANT;
          gnt_d   = gnt_q;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
`else
        state_d = ST_IDLE;
        gnt_d   = '0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bank_q  <= bank_d;
    end
  end

  assign gnt  = gnt_q;
  assign q    = bank_q;
  assign busy = (state_q == ST_GRANT);

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Self-checking bench for ff_bank_arbiter: directed vectors plus random traffic against a
// transaction-level model (owner index, last winner, bank value).
module tb_ff_bank_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [7:0]     cmd;
  logic [4*W-1:0] data;
  logic [4*W-1:0] mask;
  logic [3:0]     lock;
  logic [3:0]     gnt;
  logic [W-1:0]   q;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: which requester holds the bank (-1 = none), last winner, bank value.
  int           m_owner;
  int           m_last;
  logic [W-1:0] m_q;

  ff_bank_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .cmd  (cmd),
    .data (data),
    .mask (mask),
    .lock (lock),
    .gnt  (gnt),
    .q    (q),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_q     = '0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [7:0] c,
                            input logic [4*W-1:0] d, input logic [4*W-1:0] m,
                            input logic [3:0] lk);
    logic [1:0]   op;
    logic [W-1:0] dv, mv, val;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (r[idx]) begin
          m_owner = idx;
          m_last  = idx;
          break;
        end
      end
    end else begin
      op = c[2*m_owner +: 2];
      dv = d[W*m_owner +: W];
      mv = m[W*m_owner +: W];
      case (op)
        2'b00:   val = dv;
        2'b01:   val = '1;
        2'b10:   val = '0;
        default: val = ~m_q;
      endcase
      for (int b = 0; b < W; b++)
        if (mv[b]) m_q[b] = val[b];
`ifdef FFB_LOCK_EN
      if (!(lk[m_owner] && r[m_owner])) m_owner = -1;
`else
      m_owner = -1;
`endif
    end
  endtask

  function automatic logic [3:0] model_gnt();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // One rising edge: model consumes the inputs present at the edge, then outputs are compared.
  task automatic tick(input string tag);
    logic [3:0]     r_s, l_s;
    logic [7:0]     c_s;
    logic [4*W-1:0] d_s, m_s;
    r_s = req; c_s = cmd; d_s = data; m_s = mask; l_s = lock;
    @(posedge clk);
    #1;
    model_step(r_s, c_s, d_s, m_s, l_s);
    check({tag, ".gnt"}, 32'(gnt), 32'(model_gnt()));
    check({tag, ".q"}, 32'(q), 32'(m_q));
    check({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
  endtask

  task automatic set_req(input int i, input logic [1:0] c, input logic [W-1:0] d,
                         input logic [W-1:0] m);
    cmd[2*i +: 2]  = c;
    data[W*i +: W] = d;
    mask[W*i +: W] = m;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("rst.gnt", 32'(gnt), 32'h0);
    check("rst.q", 32'(q), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    cmd   = '0;
    data  = '0;
    mask  = '0;
    lock  = '0;
    model_reset();
    #2;
    check("init.gnt", 32'(gnt), 32'h0);
    check("init.q", 32'(q), 32'h0);
    check("init.busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single load from requester 0; req drops during GRANT and the op still applies.
    set_req(0, 2'b00, 8'hA5, 8'hFF);
    req = 4'b0001;
    tick("ld");
    check("ld.gnt0", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick("ld");
    check("ld.qA5", 32'(q), 32'hA5);
    check("ld.gnt_off", 32'(gnt), 32'h0);

    // Round-robin toggle sweep starting from q=A5 with last winner 3.
    do_reset();
    set_req(3, 2'b00, 8'hA5, 8'hFF);
    req = 4'b1000;
    tick("pre");
    req = 4'b0000;
    tick("pre");
    check("rr.qinit", 32'(q), 32'hA5);
    for (int i = 0; i < 4; i++) set_req(i, 2'b11, 8'h00, 8'h0F);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick("rr");
      check("rr.gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
      tick("rr");
      check("rr.q", 32'(q), (g % 2 == 0) ? 32'hAA : 32'hA5);
    end
    req = 4'b0000;
    tick("rr");

    // Set then clear from different requesters.
    do_reset();
    set_req(0, 2'b01, 8'h00, 8'hF0);
    req = 4'b0001;
    tick("sc");
    req = 4'b0000;
    tick("sc");
    check("sc.qF0", 32'(q), 32'hF0);
    set_req(2, 2'b10, 8'h00, 8'h30);
    req = 4'b0100;
    tick("sc");
    check("sc.gnt2", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick("sc");
    check("sc.qC0", 32'(q), 32'hC0);

    // Zero mask consumes the grant and advances priority past requester 0.
    set_req(0, 2'b11, 8'h00, 8'h00);
    req = 4'b0001;
    tick("m0");
    req = 4'b0000;
    tick("m0");
    check("m0.q", 32'(q), 32'hC0);
    set_req(1, 2'b01, 8'h00, 8'h00);
    req = 4'b0011;
    tick("m0");
    check("m0.gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick("m0");

    // Reset mid-GRANT aborts the pending load.
    do_reset();
    set_req(1, 2'b00, 8'hFF, 8'hFF);
    req = 4'b0010;
    tick("ab");
    check("ab.gnt1", 32'(gnt), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("ab.gnt_async", 32'(gnt), 32'h0);
    check("ab.q_async", 32'(q), 32'h0);
    check("ab.busy_async", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check("ab.q_held", 32'(q), 32'h0);
    reset = 1'b0;
    req   = 4'b0110;
    tick("ab");
    check("ab.gnt_low", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick("ab");

`ifdef FFB_LOCK_EN
    // Locked burst of three toggles on bit 0, then requester 1 wins.
    do_reset();
    set_req(0, 2'b11, 8'h00, 8'h01);
    set_req(1, 2'b00, 8'h00, 8'h00);
    req  = 4'b0011;
    lock = 4'b0001;
    tick("lk");
    check("lk.g1", 32'(gnt), 32'h1);
    tick("lk");
    check("lk.g2", 32'(gnt), 32'h1);
    check("lk.q1", 32'(q), 32'h01);
    tick("lk");
    check("lk.g3", 32'(gnt), 32'h1);
    check("lk.q2", 32'(q), 32'h00);
    lock = 4'b0000;
    tick("lk");
    check("lk.q3", 32'(q), 32'h01);
    check("lk.idle", 32'(gnt), 32'h0);
    tick("lk");
    check("lk.gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick("lk");
`endif

    // Random traffic against the model, with occasional resets.
    do_reset();
    repeat (400) begin
      req  = 4'($urandom);
      cmd  = 8'($urandom);
      data = $urandom;
      mask = $urandom;
      lock = 4'($urandom);
      if ($urandom_range(0, 49) == 0) do_reset();
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
